golomb_search_engine: RTL and testbench
=======================================

# golomb_search_engine

Parametrised, single-engine Golomb ruler search. It replaces the per-mark counter chain and its global ready/enabled arbitration with one sequential depth-first state machine. It holds the mark stack and a one-hot distance bitmap. Marks 1..PRESET-1 can be preset, and only the remaining marks are searched. The block keeps the best length found and a bounded buffer of all rulers of that length, which the host drains over a valid/ready handshake after `done`.

## Interface
Parameters:
- `NUMMARKS`, 5: marks per ruler including mark 0 (2..16).
- `MAXVALUE`, 63: largest legal mark position and bitmap width.
- `VW`, 6: value width, ≥ clog2(MAXVALUE+1).
- `PRESET`, 1: number of leading marks fixed by the host (1..NUMMARKS-1). Mark 0 is always 0.
- `NRES`, 4: result buffer depth (≥1).

Ports:
- `FXCLK` in 1: clock.
- `RESET_IN` in 1: asynchronous, active-low reset.
- `start` in 1: pulse to start a search. Ignored while `busy`.
- `preset_marks` in NUMMARKS*VW: mark i sits at [i*VW +: VW]. Only indices 1..PRESET-1 are used. Sampled on `start`.
- `maxlen` in VW: initial length bound. Sampled on `start`.
- `busy` out 1: search in progress.
- `done` out 1: search finished. Held until the next `start` or reset.
- `preset_err` out 1: the preset marks collide or are not strictly increasing.
- `best_len` out VW: best length found. Equals `maxlen` if no ruler was found.
- `res_count` out log2(NRES)+1: number of stored rulers.
- `res_overflow` out 1: sticky. Set when a ruler of the best length was dropped because the buffer was full.
- `res_valid` out 1, `res_ready` in 1, `res_marks` out NUMMARKS*VW: result stream, same packing as `preset_marks`.

## Operation
- Registers:
  - `m[0..NUMMARKS-1]`.
  - Stack depth `k`.
  - Candidate `cand`, VW+1 bits so overflow cannot wrap.
  - Bitmap `D[1:MAXVALUE]`.
- Combinational distance net: `newd(x, k)` = OR over j<k of onehot(x−m[j]). Because marks are distinct, `newd` has no internal duplicates.
- IDLE: on `start`:
  - Latch the presets and set best=`maxlen`.
  - Clear D, the buffer, `preset_err` and `res_overflow`.
  - Set i=1 and go to LOAD. If PRESET=1, go directly to SETUP.
- LOAD, one cycle per preset i:
  - Error if m[i]≤m[i−1] or (newd(m[i],i)&D)≠0. On error, set `preset_err` and go to DONE.
  - Otherwise D|=newd and i++. After i=PRESET−1, go to SETUP.
- SETUP: k=PRESET, cand=m[PRESET−1]+1, go to CHECK.
- CHECK (one candidate per cycle), evaluated in this priority order:
  - Prune: if cand+(NUMMARKS−1−k) > best, or cand > MAXVALUE, go to BACKTRACK.
  - Collision: if (newd(cand,k)&D)≠0, then cand++ and stay in CHECK.
  - If k=NUMMARKS−1, go to EMIT.
  - Otherwise go to ACCEPT.
- ACCEPT: m[k]=cand, D|=newd, k++, cand++. Return to CHECK.
- EMIT (m[k]=cand):
  - If cand<best: best=cand, flush the buffer, write this ruler at slot 0, count=1.
  - If cand=best and count<NRES: append the ruler.
  - If cand=best and the buffer is full: set `res_overflow`.
  - Then go to BACKTRACK, since longer last marks cannot improve.
- BACKTRACK:
  - If k−1 < PRESET, go to DONE.
  - Otherwise D&=~newd(m[k−1],k−1), cand=m[k−1]+1, k−−, and go to CHECK.
- DONE:
  - `done`=1, read pointer=0.
  - `res_valid`=(rdptr<count). Each valid&ready beat increments rdptr. `res_marks`=buf[rdptr].
  - `start` restarts from IDLE behaviour.

## Timing
- Reset values: `busy` 0, `done` 0, `preset_err` 0, `best_len` 0, `res_count` 0, `res_overflow` 0, `res_valid` 0, `res_marks` 0. State is IDLE.
- `busy` rises the cycle after `start` and falls when `done` rises.
- LOAD takes PRESET−1 cycles. SETUP, ACCEPT, EMIT and BACKTRACK take 1 cycle each.
- The `res_*` outputs are registered, and `res_marks` is updated on the cycle after each handshake.
- Reset asserted mid-search aborts immediately and all outputs return to their reset values.
- `start` while busy has no effect. `start` in DONE discards any unread results.

## Test plan
- NUMMARKS=4, PRESET=1, `maxlen`=15:
  - 0,1,3,7 found first, then replaced.
  - Final state: best 6, count 2, results {0,1,4,6} then {0,2,5,6}, overflow 0.
- NUMMARKS=5, NRES=2, `maxlen`=20: best 11, count 2, {0,1,4,9,11} and {0,2,7,8,11}, overflow 1.
- NUMMARKS=5, PRESET=2, m1=2: {0,2,7,8,11} and {0,2,7,10,11}, best 11.
- PRESET=3, m1=2, m2=4 (distance 2 repeats): `done` with `preset_err`=1, count 0.
- NUMMARKS=4, `maxlen`=5: `done`, count 0, best 5, `res_valid` never asserted.
- Reset mid-search, then `start` with NUMMARKS=4: all outputs return to their reset values on reset, and the rerun gives results identical to the first scenario.
- `res_ready` toggled randomly: every result is read exactly once, in buffer order.

Source files
------------

// File: rtl/golomb_search_engine.sv
// golomb_search_engine: one sequential depth-first Golomb ruler search.
// Holds a mark stack and a one-hot distance bitmap, tracks the best length,
// and buffers every ruler of that length for a valid/ready drain after done.
module golomb_search_engine #(
    parameter int NUMMARKS = 5,
    parameter int MAXVALUE = 63,
    parameter int VW       = 6,
    parameter int PRESET   = 1,
    parameter int NRES     = 4
) (
    input  logic                   FXCLK,
    input  logic                   RESET_IN,
    input  logic                   start,
    input  logic [NUMMARKS*VW-1:0] preset_marks,
    input  logic [VW-1:0]          maxlen,
    output logic                   busy,
    output logic                   done,
    output logic                   preset_err,
    output logic [VW-1:0]          best_len,
    output logic [$clog2(NRES):0]  res_count,
    output logic                   res_overflow,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NUMMARKS*VW-1:0] res_marks
);
    localparam int KW = $clog2(NUMMARKS + 1);
    localparam int CW = $clog2(NRES) + 1;
    localparam int EW = VW + 2;  // headroom for cand plus remaining marks

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_CHECK, S_ACCEPT, S_EMIT, S_BACKTRACK, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [VW-1:0]          m_q [NUMMARKS];
    logic [VW-1:0]          m_d [NUMMARKS];
    logic [KW-1:0]          k_q, k_d;
    logic [VW:0]            cand_q, cand_d;
    logic [MAXVALUE:1]      dmap_q, dmap_d;
    logic [VW-1:0]          best_q, best_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          rdptr_q, rdptr_d;
    logic                   err_q, err_d;
    logic                   ovf_q, ovf_d;
    logic                   res_valid_q, res_valid_d;
    logic [NUMMARKS*VW-1:0] res_marks_q, res_marks_d;
    logic [NUMMARKS*VW-1:0] rbuf_q [NRES];

    logic                   wr_en;
    logic [CW-1:0]          wr_idx;
    logic [NUMMARKS*VW-1:0] wr_data;

    logic [VW-1:0]          m_at_k, m_below_k;
    logic [VW:0]            dist_x, diff;
    logic [KW-1:0]          dist_k;
    logic [MAXVALUE:1]      nd;
    logic                   collide;
    logic [EW-1:0]          reach;

    // Mark 0 is always zero and marks at or beyond PRESET are searched, so
    // those slices of the host word are never loaded.
    logic unused_preset;
    assign unused_preset = ^preset_marks;

    // Pick the marks at stack depth k and k-1.
    always_comb begin
        m_at_k    = '0;
        m_below_k = '0;
        for (int j = 0; j < NUMMARKS; j++) begin
            if (KW'(j) == k_q)     m_at_k    = m_q[j];
            if (KW'(j + 1) == k_q) m_below_k = m_q[j];
        end
    end

    // Shared distance net: onehot(x - m[j]) for every j below the chosen depth.
    always_comb begin
        dist_x = {1'b0, m_at_k};
        dist_k = k_q;
        if (state_q == S_BACKTRACK) begin
            dist_x = {1'b0, m_below_k};
            dist_k = k_q - 1'b1;
        end else if (state_q != S_LOAD) begin
            dist_x = cand_q;
        end
        nd   = '0;
        diff = '0;
        for (int j = 0; j < NUMMARKS; j++) begin
            if (KW'(j) < dist_k && dist_x > {1'b0, m_q[j]}) begin
                diff = dist_x - {1'b0, m_q[j]};
                for (int b = 1; b <= MAXVALUE; b++) begin
                    if (diff == (VW+1)'(b)) nd[b] = 1'b1;
                end
            end
        end
    end

    assign collide = |(nd & dmap_q);
    assign reach   = EW'(cand_q) + EW'(NUMMARKS - 1) - EW'(k_q);

    // Completed ruler: stacked marks below the last slot plus the candidate.
    always_comb begin
        wr_data = '0;
        for (int j = 0; j < NUMMARKS - 1; j++) wr_data[j*VW +: VW] = m_q[j];
        wr_data[(NUMMARKS-1)*VW +: VW] = cand_q[VW-1:0];
    end

    // Search FSM: next state, stack, bitmap and result bookkeeping.
    always_comb begin
        // NOTE: every _d starts from its current value so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        cand_d  = cand_q;
        dmap_d  = dmap_q;
        best_d  = best_q;
        count_d = count_q;
        rdptr_d = rdptr_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = '0;

        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                if (m_at_k <= m_below_k || collide) begin
                    err_d   = 1'b1;
                    rdptr_d = '0;
                    state_d = S_DONE;
                end else begin
                    dmap_d = dmap_q | nd;
                    k_d    = k_q + 1'b1;
                    if (k_q == KW'(PRESET - 1)) state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                k_d     = KW'(PRESET);
                cand_d  = {1'b0, m_q[PRESET-1]} + 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (reach > EW'(best_q) || cand_q > (VW+1)'(MAXVALUE)) begin
                    state_d = S_BACKTRACK;
                end else if (collide) begin
                    cand_d = cand_q + 1'b1;
                end else if (k_q == KW'(NUMMARKS - 1)) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                for (int j = 0; j < NUMMARKS; j++) begin
                    if (KW'(j) == k_q) m_d[j] = cand_q[VW-1:0];
                end
                dmap_d  = dmap_q | nd;
                k_d     = k_q + 1'b1;
                cand_d  = cand_q + 1'b1;
                state_d = S_CHECK;
            end
            S_EMIT: begin
                m_d[NUMMARKS-1] = cand_q[VW-1:0];
                if (cand_q < {1'b0, best_q}) begin
                    best_d  = cand_q[VW-1:0];
                    count_d = CW'(1);
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                end else if (cand_q == {1'b0, best_q}) begin
                    if (count_q < CW'(NRES)) begin
                        wr_en   = 1'b1;
                        wr_idx  = count_q;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // A longer last mark can never beat this one.
                state_d = S_BACKTRACK;
            end
            S_BACKTRACK: begin
                if (k_q <= KW'(PRESET)) begin
                    rdptr_d = '0;
                    state_d = S_DONE;
                end else begin
                    dmap_d  = dmap_q & ~nd;
                    cand_d  = {1'b0, m_below_k} + 1'b1;
                    k_d     = k_q - 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                if (res_valid_q && res_ready) rdptr_d = rdptr_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A start outside a search re-initialises and drops unread results.
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            m_d[0] = '0;
            for (int i = 1; i < PRESET; i++) m_d[i] = preset_marks[i*VW +: VW];
            best_d  = maxlen;
            dmap_d  = '0;
            count_d = '0;
            rdptr_d = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            k_d     = KW'(1);
            state_d = (PRESET == 1) ? S_SETUP : S_LOAD;
        end
    end

    // Registered result stream, lined up with the read pointer after each beat.
    always_comb begin
        res_valid_d = (state_d == S_DONE) && (rdptr_d < count_d);
        res_marks_d = '0;
        for (int r = 0; r < NRES; r++) begin
            if (res_valid_d && CW'(r) == rdptr_d) res_marks_d = rbuf_q[r];
        end
    end

    // State and datapath registers.
    always_ff @(posedge FXCLK or negedge RESET_IN) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_IN) begin
            state_q     <= S_IDLE;
            for (int j = 0; j < NUMMARKS; j++) m_q[j] <= '0;
            k_q         <= '0;
            cand_q      <= '0;
            dmap_q      <= '0;
            best_q      <= '0;
            count_q     <= '0;
            rdptr_q     <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_marks_q <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            k_q         <= k_d;
            cand_q      <= cand_d;
            dmap_q      <= dmap_d;
            best_q      <= best_d;
            count_q     <= count_d;
            rdptr_q     <= rdptr_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_marks_q <= res_marks_d;
        end
    end

    // Result buffer writes.
    always_ff @(posedge FXCLK) begin
        // NOTE: the buffer has no reset; only entries below res_count are ever
        // read, so clearing the count is enough to empty it.
        for (int r = 0; r < NRES; r++) begin
            if (wr_en && CW'(r) == wr_idx) rbuf_q[r] <= wr_data;
        end
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign preset_err   = err_q;
    assign best_len     = best_q;
    assign res_count    = count_q;
    assign res_overflow = ovf_q;
    assign res_valid    = res_valid_q;
    assign res_marks    = res_marks_q;

endmodule

// File: tb/tb_golomb_search_engine.sv
// Directed bench for golomb_search_engine: four parameterisations, a vector
// table of complete searches, and hand sequences for restart/reset corners.
`timescale 1ns/1ps
module tb_golomb_search_engine;

    logic        clk;
    logic        rst_n;
    logic        start_v   [4];
    logic [29:0] pm_v      [4];
    logic [5:0]  maxlen_v  [4];
    logic        ready_v   [4];
    logic        busy_v    [4];
    logic        done_v    [4];
    logic        err_v     [4];
    logic        ovf_v     [4];
    logic        valid_v   [4];
    logic [5:0]  best_v    [4];
    int          count_v   [4];
    logic [29:0] marks_v   [4];

    logic [2:0]  a_count, c_count, d_count;
    logic [1:0]  b_count;
    logic [23:0] a_marks;
    logic [29:0] b_marks, c_marks, d_marks;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign count_v[0] = int'(a_count);
    assign count_v[1] = int'(b_count);
    assign count_v[2] = int'(c_count);
    assign count_v[3] = int'(d_count);
    assign marks_v[0] = {6'd0, a_marks};
    assign marks_v[1] = b_marks;
    assign marks_v[2] = c_marks;
    assign marks_v[3] = d_marks;

    // 4 marks, no presets.
    golomb_search_engine #(.NUMMARKS(4), .MAXVALUE(63), .VW(6), .PRESET(1), .NRES(4)) dut_a (
        .FXCLK(clk), .RESET_IN(rst_n), .start(start_v[0]), .preset_marks(pm_v[0][23:0]),
        .maxlen(maxlen_v[0]), .busy(busy_v[0]), .done(done_v[0]), .preset_err(err_v[0]),
        .best_len(best_v[0]), .res_count(a_count), .res_overflow(ovf_v[0]),
        .res_valid(valid_v[0]), .res_ready(ready_v[0]), .res_marks(a_marks));

    // 5 marks, two-entry buffer.
    golomb_search_engine #(.NUMMARKS(5), .MAXVALUE(63), .VW(6), .PRESET(1), .NRES(2)) dut_b (
        .FXCLK(clk), .RESET_IN(rst_n), .start(start_v[1]), .preset_marks(pm_v[1]),
        .maxlen(maxlen_v[1]), .busy(busy_v[1]), .done(done_v[1]), .preset_err(err_v[1]),
        .best_len(best_v[1]), .res_count(b_count), .res_overflow(ovf_v[1]),
        .res_valid(valid_v[1]), .res_ready(ready_v[1]), .res_marks(b_marks));

    // 5 marks, mark 1 preset.
    golomb_search_engine #(.NUMMARKS(5), .MAXVALUE(63), .VW(6), .PRESET(2), .NRES(4)) dut_c (
        .FXCLK(clk), .RESET_IN(rst_n), .start(start_v[2]), .preset_marks(pm_v[2]),
        .maxlen(maxlen_v[2]), .busy(busy_v[2]), .done(done_v[2]), .preset_err(err_v[2]),
        .best_len(best_v[2]), .res_count(c_count), .res_overflow(ovf_v[2]),
        .res_valid(valid_v[2]), .res_ready(ready_v[2]), .res_marks(c_marks));

    // 5 marks, marks 1 and 2 preset.
    golomb_search_engine #(.NUMMARKS(5), .MAXVALUE(63), .VW(6), .PRESET(3), .NRES(4)) dut_d (
        .FXCLK(clk), .RESET_IN(rst_n), .start(start_v[3]), .preset_marks(pm_v[3]),
        .maxlen(maxlen_v[3]), .busy(busy_v[3]), .done(done_v[3]), .preset_err(err_v[3]),
        .best_len(best_v[3]), .res_count(d_count), .res_overflow(ovf_v[3]),
        .res_valid(valid_v[3]), .res_ready(ready_v[3]), .res_marks(d_marks));

    typedef struct {
        int          dut;
        logic [5:0]  maxlen;
        logic [5:0]  m1;
        logic [5:0]  m2;
        logic        exp_err;
        logic [5:0]  exp_best;
        int          exp_count;
        logic        chk_ovf;
        logic        exp_ovf;
        logic        chk_first;
        int          exp_first;  // first best_len differing from maxlen, -1 if none
        logic [29:0] exp_r0;
        logic [29:0] exp_r1;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [29:0] r5(input int a, input int b, input int c,
                                       input int d, input int e);
        return {6'(e), 6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic logic [29:0] r4(input int a, input int b, input int c, input int d);
        return {6'd0, 6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int s);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, input string name);
        int cyc;
        cyc = 0;
        while (!done_v[s] && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " done_reached"}, done_v[s], 1);
    endtask

    task automatic run_vec(input int v, input string tag);
        int          s;
        int          cyc;
        int          beats;
        int          first_best;
        logic        saw_valid;
        logic [29:0] exp_beat;
        s = vecs[v].dut;
        pm_v[s]        = '0;
        pm_v[s][11:6]  = vecs[v].m1;
        pm_v[s][17:12] = vecs[v].m2;
        maxlen_v[s]    = vecs[v].maxlen;
        pulse_start(s);
        check({tag, " busy_after_start"}, busy_v[s], 1);

        first_best = -1;
        saw_valid  = 1'b0;
        cyc        = 0;
        while (!done_v[s] && cyc < 20000) begin
            if (valid_v[s]) saw_valid = 1'b1;
            if (first_best < 0 && best_v[s] != vecs[v].maxlen) first_best = int'(best_v[s]);
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_reached"}, done_v[s], 1);
        check({tag, " valid_before_done"}, saw_valid, 0);
        check({tag, " busy_at_done"}, busy_v[s], 0);
        check({tag, " preset_err"}, err_v[s], vecs[v].exp_err);
        check({tag, " best_len"}, best_v[s], vecs[v].exp_best);
        check({tag, " res_count"}, count_v[s], vecs[v].exp_count);
        if (vecs[v].chk_ovf) check({tag, " res_overflow"}, ovf_v[s], vecs[v].exp_ovf);
        if (vecs[v].chk_first) check({tag, " first_best"}, first_best, vecs[v].exp_first);

        // Drain with a randomly toggling ready; each beat is captured the
        // half-cycle before the edge that completes it.
        beats = 0;
        cyc   = 0;
        while (beats < vecs[v].exp_count && cyc < 2000) begin
            ready_v[s] = 1'($urandom_range(0, 1));
            if (valid_v[s] && ready_v[s]) begin
                exp_beat = (beats == 0) ? vecs[v].exp_r0 : vecs[v].exp_r1;
                check($sformatf("%s beat%0d", tag, beats), marks_v[s], exp_beat);
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " beats_read"}, beats, vecs[v].exp_count);
        ready_v[s] = 1'b1;
        check({tag, " valid_after_drain"}, valid_v[s], 0);
        @(negedge clk);
        check({tag, " valid_stays_low"}, valid_v[s], 0);
        check({tag, " done_held"}, done_v[s], 1);
        ready_v[s] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int s, input string tag);
        check({tag, " busy"}, busy_v[s], 0);
        check({tag, " done"}, done_v[s], 0);
        check({tag, " preset_err"}, err_v[s], 0);
        check({tag, " best_len"}, best_v[s], 0);
        check({tag, " res_count"}, count_v[s], 0);
        check({tag, " res_overflow"}, ovf_v[s], 0);
        check({tag, " res_valid"}, valid_v[s], 0);
        check({tag, " res_marks"}, marks_v[s], 0);
    endtask

    initial begin
        vecs[0] = '{dut: 0, maxlen: 6'd15, m1: 6'd0, m2: 6'd0, exp_err: 1'b0, exp_best: 6'd6,
                    exp_count: 2, chk_ovf: 1'b1, exp_ovf: 1'b0, chk_first: 1'b1, exp_first: 7,
                    exp_r0: r4(0, 1, 4, 6), exp_r1: r4(0, 2, 5, 6)};
        vecs[1] = '{dut: 1, maxlen: 6'd20, m1: 6'd0, m2: 6'd0, exp_err: 1'b0, exp_best: 6'd11,
                    exp_count: 2, chk_ovf: 1'b1, exp_ovf: 1'b1, chk_first: 1'b0, exp_first: 0,
                    exp_r0: r5(0, 1, 4, 9, 11), exp_r1: r5(0, 2, 7, 8, 11)};
        vecs[2] = '{dut: 2, maxlen: 6'd20, m1: 6'd2, m2: 6'd0, exp_err: 1'b0, exp_best: 6'd11,
                    exp_count: 2, chk_ovf: 1'b0, exp_ovf: 1'b0, chk_first: 1'b0, exp_first: 0,
                    exp_r0: r5(0, 2, 7, 8, 11), exp_r1: r5(0, 2, 7, 10, 11)};
        vecs[3] = '{dut: 3, maxlen: 6'd20, m1: 6'd2, m2: 6'd4, exp_err: 1'b1, exp_best: 6'd20,
                    exp_count: 0, chk_ovf: 1'b1, exp_ovf: 1'b0, chk_first: 1'b1, exp_first: -1,
                    exp_r0: '0, exp_r1: '0};
        vecs[4] = '{dut: 0, maxlen: 6'd5, m1: 6'd0, m2: 6'd0, exp_err: 1'b0, exp_best: 6'd5,
                    exp_count: 0, chk_ovf: 1'b1, exp_ovf: 1'b0, chk_first: 1'b1, exp_first: -1,
                    exp_r0: '0, exp_r1: '0};

        for (int s = 0; s < 4; s++) begin
            start_v[s]  = 1'b0;
            pm_v[s]     = '0;
            maxlen_v[s] = '0;
            ready_v[s]  = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_vec(v, $sformatf("vec%0d", v));

        // start while busy must not reload maxlen.
        maxlen_v[0] = 6'd15;
        pulse_start(0);
        repeat (3) @(negedge clk);
        maxlen_v[0] = 6'd5;
        pulse_start(0);
        check("busy_start best_len", best_v[0], 15);
        wait_done(0, "busy_start");
        check("busy_start final_best", best_v[0], 6);
        check("busy_start final_count", count_v[0], 2);
        check("busy_start valid_pending", valid_v[0], 1);

        // start in DONE drops the unread results.
        maxlen_v[0] = 6'd15;
        pulse_start(0);
        check("discard valid", valid_v[0], 0);
        check("discard busy", busy_v[0], 1);
        check("discard done", done_v[0], 0);

        // Abort that search with a mid-cycle reset, then rerun it cleanly.
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(0, "rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
